// File: rtl/uart_reg_pkg.sv
// Shared definitions for the 16750 register-bus controller: register map,
// LSR bit positions and the bus sequencer state encoding.
package uart_reg_pkg;

    localparam logic [2:0] ADDR_RBR = 3'd0;
    localparam logic [2:0] ADDR_THR = 3'd0;
    localparam logic [2:0] ADDR_IER = 3'd1;
    localparam logic [2:0] ADDR_FCR = 3'd2;
    localparam logic [2:0] ADDR_LCR = 3'd3;
    localparam logic [2:0] ADDR_MCR = 3'd4;
    localparam logic [2:0] ADDR_LSR = 3'd5;
    localparam logic [2:0] ADDR_MSR = 3'd6;
    localparam logic [2:0] ADDR_SCR = 3'd7;
    localparam logic [2:0] ADDR_DLL = 3'd0;
    localparam logic [2:0] ADDR_DLM = 3'd1;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_PE   = 2;
    localparam int LSR_FE   = 3;
    localparam int LSR_BI   = 4;
    localparam int LSR_THRE = 5;

    localparam logic [7:0] DLAB_MASK = 8'h80;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_CFG_LCR_DLAB,
        ST_CFG_DLL,
        ST_CFG_DLM,
        ST_CFG_LCR,
        ST_CFG_FCR,
        ST_CFG_IER,
        ST_IDLE,
        ST_POLL_LSR,
        ST_READ_RBR,
        ST_WRITE_THR
    } ctrl_state_t;

endpackage

// File: rtl/uart_reg_ctrl_fifo.sv
// Small synchronous FIFO buffering received bytes; head is read straight
// from storage so rx_data is valid in the same cycle as rx_valid.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/uart_reg_ctrl.sv
// Host-side sequencer for a 16750 register bus: configures the UART, then
// polls LSR to move RX bytes into a FIFO and TX bytes into THR.
module uart_reg_ctrl
    import uart_reg_pkg::*;
#(
    parameter logic [15:0] DIVISOR    = 16'd18,
    parameter logic [7:0]  LCR_VAL    = 8'h03,
    parameter logic [7:0]  FCR_VAL    = 8'h00,
    parameter logic [7:0]  IER_VAL    = 8'h00,
    parameter int          RD_LAT     = 1,
    parameter int          RX_DEPTH   = 4,
    parameter logic [7:0]  MATCH_BYTE = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_restart,
    output logic       cfg_done,
    output logic       u_cs,
    output logic       u_wr,
    output logic       u_rd,
    output logic [2:0] u_a,
    output logic [7:0] u_din,
    input  logic [7:0] u_dout,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rx_overrun,
    output logic       line_err,
    output logic       match_hit,
    input  logic       err_clr
);

    localparam logic [2:0] WR_LAST = 3'd2;
    localparam logic [2:0] RD_LAST = 3'(RD_LAT + 2);

    ctrl_state_t state_reg, state_next;
    logic [2:0]  phase_reg, phase_next;
    logic [7:0]  rd_data_reg;
    logic        hold_valid_reg;
    logic [7:0]  hold_data_reg;
    logic        restart_pend_reg;
    logic        rx_overrun_reg;
    logic        line_err_reg;
    logic        match_hit_reg;

    logic [2:0]  acc_a;
    logic [7:0]  acc_din;
    logic        acc_read;
    logic        in_access;
    logic        acc_end;
    logic [2:0]  last_phase;
    logic        capture;
    logic        poll_end;
    logic        rx_push;
    logic        tx_done;
    logic        tx_accept;
    logic        ovr_set;
    logic        err_set;
    logic        fifo_full;
    logic        fifo_empty;

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rd_data_reg),
        .pop       (rx_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (rx_data)
    );

    assign cfg_done   = (state_reg == ST_IDLE) || (state_reg == ST_POLL_LSR) ||
                        (state_reg == ST_READ_RBR) || (state_reg == ST_WRITE_THR);
    assign tx_ready   = cfg_done && !hold_valid_reg;
    assign tx_accept  = tx_valid && tx_ready;
    assign rx_valid   = !fifo_empty;
    assign rx_overrun = rx_overrun_reg;
    assign line_err   = line_err_reg;
    assign match_hit  = match_hit_reg;

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        acc_a      = 3'd0;
        acc_din    = 8'h00;
        acc_read   = 1'b0;

        case (state_reg)
            ST_CFG_LCR_DLAB: begin acc_a = ADDR_LCR; acc_din = DLAB_MASK | LCR_VAL; end
            ST_CFG_DLL:      begin acc_a = ADDR_DLL; acc_din = DIVISOR[7:0];        end
            ST_CFG_DLM:      begin acc_a = ADDR_DLM; acc_din = DIVISOR[15:8];       end
            ST_CFG_LCR:      begin acc_a = ADDR_LCR; acc_din = LCR_VAL;             end
            ST_CFG_FCR:      begin acc_a = ADDR_FCR; acc_din = FCR_VAL;             end
            ST_CFG_IER:      begin acc_a = ADDR_IER; acc_din = IER_VAL;             end
            ST_POLL_LSR:     begin acc_a = ADDR_LSR; acc_read = 1'b1;               end
            ST_READ_RBR:     begin acc_a = ADDR_RBR; acc_read = 1'b1;               end
            ST_WRITE_THR:    begin acc_a = ADDR_THR; acc_din = hold_data_reg;       end
            default: ;
        endcase

        // Every state other than RESET and IDLE is one bus access; phase 0 is SETUP
        // and the last phase is RELEASE.
        in_access  = (state_reg != ST_RESET) && (state_reg != ST_IDLE);
        last_phase = acc_read ? RD_LAST : WR_LAST;
        acc_end    = in_access && (phase_reg == last_phase);

        u_cs  = in_access && !acc_end;
        u_wr  = in_access && !acc_read && (phase_reg == 3'd1);
        u_rd  = acc_read && (phase_reg != 3'd0) && !acc_end;
        u_a   = in_access ? acc_a : 3'd0;
        u_din = in_access ? acc_din : 8'h00;

        capture  = acc_read && (phase_reg == RD_LAST - 3'd1);
        poll_end = acc_end && (state_reg == ST_POLL_LSR);
        rx_push  = acc_end && (state_reg == ST_READ_RBR);
        tx_done  = acc_end && (state_reg == ST_WRITE_THR);
        ovr_set  = poll_end && ((rd_data_reg[LSR_DR] && fifo_full) || rd_data_reg[LSR_OE]);
        err_set  = poll_end && (rd_data_reg[LSR_PE] || rd_data_reg[LSR_FE] || rd_data_reg[LSR_BI]);

        if (in_access) phase_next = acc_end ? 3'd0 : phase_reg + 3'd1;

        case (state_reg)
            ST_RESET:        state_next = ST_CFG_LCR_DLAB;
            ST_CFG_LCR_DLAB: if (acc_end) state_next = ST_CFG_DLL;
            ST_CFG_DLL:      if (acc_end) state_next = ST_CFG_DLM;
            ST_CFG_DLM:      if (acc_end) state_next = ST_CFG_LCR;
            ST_CFG_LCR:      if (acc_end) state_next = ST_CFG_FCR;
            ST_CFG_FCR:      if (acc_end) state_next = ST_CFG_IER;
            ST_CFG_IER:      if (acc_end) state_next = ST_IDLE;
            ST_IDLE:         state_next = (restart_pend_reg || cfg_restart) ? ST_CFG_LCR_DLAB
                                                                             : ST_POLL_LSR;
            ST_POLL_LSR: begin
                // RX takes precedence; a full FIFO leaves the byte in the UART.
                if (acc_end) begin
                    if (rd_data_reg[LSR_DR])
                        state_next = fifo_full ? ST_IDLE : ST_READ_RBR;
                    else if (rd_data_reg[LSR_THRE] && hold_valid_reg)
                        state_next = ST_WRITE_THR;
                    else
                        state_next = ST_IDLE;
                end
            end
            ST_READ_RBR:     if (acc_end) state_next = ST_IDLE;
            ST_WRITE_THR:    if (acc_end) state_next = ST_IDLE;
            default:         state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_RESET;
            phase_reg        <= 3'd0;
            rd_data_reg      <= 8'h00;
            hold_valid_reg   <= 1'b0;
            hold_data_reg    <= 8'h00;
            restart_pend_reg <= 1'b0;
            rx_overrun_reg   <= 1'b0;
            line_err_reg     <= 1'b0;
            match_hit_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;

            if (capture) rd_data_reg <= u_dout;

            if (tx_accept) begin
                hold_valid_reg <= 1'b1;
                hold_data_reg  <= tx_data;
            end else if (tx_done) begin
                hold_valid_reg <= 1'b0;
            end

            if (state_reg == ST_IDLE)
                restart_pend_reg <= 1'b0;
            else if (cfg_restart)
                restart_pend_reg <= 1'b1;

            // A set event in the same cycle as err_clr wins.
            if (ovr_set)      rx_overrun_reg <= 1'b1;
            else if (err_clr) rx_overrun_reg <= 1'b0;

            if (err_set)      line_err_reg <= 1'b1;
            else if (err_clr) line_err_reg <= 1'b0;

            if (rx_push) match_hit_reg <= (rd_data_reg == MATCH_BYTE);
        end
    end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Directed bench for uart_reg_ctrl with a behavioural UART register model.
module tb_uart_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_restart = 1'b0;
    logic       cfg_done;
    logic       u_cs, u_wr, u_rd;
    logic [2:0] u_a;
    logic [7:0] u_din, u_dout;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       rx_overrun, line_err, match_hit;
    logic       err_clr = 1'b0;

    always #5 clk = ~clk;

    uart_reg_ctrl dut (
        .clk(clk), .rst(rst), .cfg_restart(cfg_restart), .cfg_done(cfg_done),
        .u_cs(u_cs), .u_wr(u_wr), .u_rd(u_rd), .u_a(u_a), .u_din(u_din), .u_dout(u_dout),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_overrun(rx_overrun), .line_err(line_err), .match_hit(match_hit),
        .err_clr(err_clr)
    );

    // UART model: pending RX bytes in a simple array, LSR built from it.
    logic [7:0] model_bytes [0:63];
    int         m_head = 0;
    int         m_tail = 0;
    logic       thre = 1'b1;
    logic [7:0] lsr_err = 8'h00;
    logic       dr;
    logic       rd_q = 1'b0;

    assign dr     = (m_head != m_tail);
    assign u_dout = (u_a == 3'd5) ? ({2'b00, thre, 4'b0000, dr} | (lsr_err & 8'h1E)) :
                    (u_a == 3'd0) ? model_bytes[m_head[5:0]] : 8'h00;

    int          cyc = 0;
    logic [10:0] wr_log [0:63];
    int          wr_cyc [0:63];
    int          wr_n = 0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_q <= u_rd && (u_a == 3'd0);
        if (rd_q && !u_rd && dr) m_head <= m_head + 1;
        if (u_wr && wr_n < 64) begin
            wr_log[wr_n] <= {u_a, u_din};
            wr_cyc[wr_n] <= cyc + 1;
            wr_n         <= wr_n + 1;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    localparam int P_RXV  = 0;
    localparam int P_CFG  = 1;
    localparam int P_NCFG = 2;
    localparam int P_OVR  = 3;
    localparam int P_TXR  = 4;
    localparam int P_LE   = 5;

    function automatic logic probe(input int sel);
        case (sel)
            P_RXV:   return rx_valid;
            P_CFG:   return cfg_done;
            P_NCFG:  return !cfg_done;
            P_OVR:   return rx_overrun;
            P_TXR:   return tx_ready;
            P_LE:    return line_err;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name, output int k);
        k = 0;
        while (!probe(sel) && k < 400) begin
            tick();
            k++;
        end
        check(name, 32'(k < 400), 32'd1);
    endtask

    task automatic push_model(input logic [7:0] b);
        model_bytes[m_tail[5:0]] = b;
        m_tail++;
    endtask

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } cfg_vec_t;

    typedef struct {
        logic [7:0] b;
        logic [7:0] err;
        logic [7:0] exp_data;
        logic       exp_match;
        logic       exp_le;
        logic       exp_ovr;
    } rx_vec_t;

    cfg_vec_t cfg_exp [6];
    rx_vec_t  vecs [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        int hbase;

        for (int i = 0; i < 64; i++) model_bytes[i] = 8'h00;

        cfg_exp[0] = '{3'd3, 8'h83};
        cfg_exp[1] = '{3'd0, 8'h12};
        cfg_exp[2] = '{3'd1, 8'h00};
        cfg_exp[3] = '{3'd3, 8'h03};
        cfg_exp[4] = '{3'd2, 8'h00};
        cfg_exp[5] = '{3'd1, 8'h00};

        vecs[0] = '{8'h20, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h41, 8'h00, 8'h41, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h7E, 8'h0C, 8'h7E, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h20, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h55, 8'h02, 8'h55, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({u_cs, u_wr, u_rd, u_a, u_din, cfg_done, rx_valid, tx_ready,
                   rx_overrun, line_err, match_hit}), 32'd0);

        // Configuration sequence
        @(negedge clk);
        rst = 1'b0;
        wait_for(P_CFG, "cfg_wait", k);
        check("cfg_done_latency", 32'(k), 32'd19);
        check("cfg_write_count", 32'(wr_n), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("cfg_write%0d", i), 32'(wr_log[i]), 32'({cfg_exp[i].a, cfg_exp[i].d}));

        // RX vectors with consumer always ready
        @(negedge clk);
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            lsr_err = vecs[i].err;
            push_model(vecs[i].b);
            wait_for(P_RXV, $sformatf("rx_vec%0d_wait", i), k);
            check($sformatf("rx_vec%0d", i), 32'({rx_data, match_hit, line_err, rx_overrun}),
                  32'({vecs[i].exp_data, vecs[i].exp_match, vecs[i].exp_le, vecs[i].exp_ovr}));
            tick();
            check($sformatf("rx_vec%0d_drop", i), 32'(rx_valid), 32'd0);
            if (vecs[i].exp_le || vecs[i].exp_ovr) begin
                lsr_err = 8'h00;
                wait_cycles(12);
                @(negedge clk);
                err_clr = 1'b1;
                tick();
                check($sformatf("rx_vec%0d_clr", i), 32'({line_err, rx_overrun}), 32'd0);
                err_clr = 1'b0;
            end
        end

        // TX byte held while THRE=0; RBR read proceeds first
        @(negedge clk);
        thre = 1'b0;
        push_model(8'h33);
        check("tx_ready_idle", 32'(tx_ready), 32'd1);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        check("tx_ready_drop", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        wait_for(P_RXV, "tx_rx_wait", k);
        check("tx_rx_first", 32'(rx_data), 32'h33);
        base = wr_n;
        wait_cycles(12);
        check("thr_blocked", 32'(wr_n - base), 32'd0);
        thre = 1'b1;
        wait_for(P_TXR, "tx_ready_wait", k);
        check("thr_count", 32'(wr_n - base), 32'd1);
        check("thr_data", 32'(wr_log[wr_n-1]), 32'({3'd0, 8'h55}));
        check("tx_ready_after_release", 32'(cyc), 32'(wr_cyc[wr_n-1] + 1));

        // err_clr on the same edge as a line-error set: set wins
        lsr_err = 8'h08;
        wait_for(P_LE, "le_wait", k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(u_a == 3'd5 && !u_cs) && k < 50);
        check("le_sync_wait", 32'(k < 50), 32'd1);
        err_clr = 1'b1;
        tick();
        check("le_set_wins", 32'(line_err), 32'd1);
        err_clr = 1'b0;
        lsr_err = 8'h00;
        wait_cycles(12);
        @(negedge clk);
        err_clr = 1'b1;
        tick();
        check("le_clear", 32'(line_err), 32'd0);
        err_clr = 1'b0;

        // FIFO backpressure and overrun
        @(negedge clk);
        rx_ready = 1'b0;
        hbase = m_head;
        for (int i = 0; i < 5; i++) push_model(8'(8'h10 + i));
        wait_for(P_OVR, "ovr_wait", k);
        check("ovr_reads", 32'(m_head - hbase), 32'd4);
        wait_cycles(20);
        check("ovr_no_5th", 32'({rx_overrun, 8'(m_head - hbase)}), 32'({1'b1, 8'd4}));
        @(negedge clk);
        check("ovr_pop0", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h10}));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        k = 0;
        while (m_head - hbase < 5 && k < 100) begin
            tick();
            k++;
        end
        check("ovr_5th_read", 32'(m_head - hbase), 32'd5);
        wait_cycles(15);
        @(negedge clk);
        err_clr = 1'b1;
        tick();
        check("ovr_clear", 32'(rx_overrun), 32'd0);
        err_clr = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("ovr_drain%0d", j), 32'({rx_valid, rx_data}), 32'({1'b1, 8'(8'h11 + j)}));
            rx_ready = 1'b1;
        end
        @(negedge clk);
        check("ovr_drained", 32'(rx_valid), 32'd0);
        rx_ready = 1'b0;

        // Runtime reconfiguration keeps FIFO contents
        push_model(8'h66);
        wait_for(P_RXV, "restart_rx_wait", k);
        base = wr_n;
        @(negedge clk);
        cfg_restart = 1'b1;
        @(negedge clk);
        cfg_restart = 1'b0;
        wait_for(P_NCFG, "restart_drop_wait", k);
        wait_for(P_CFG, "restart_done_wait", k);
        check("restart_writes", 32'(wr_n - base), 32'd6);
        check("restart_first_write", 32'(wr_log[base]), 32'({3'd3, 8'h83}));
        check("restart_fifo_kept", 32'({rx_valid, rx_data}), 32'({1'b1, 8'h66}));

        // Reset during an RBR read
        push_model(8'h77);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(u_rd && u_a == 3'd0) && k < 100);
        check("midread_wait", 32'(k < 100), 32'd1);
        rst = 1'b1;
        tick();
        check("midread_reset", 32'({u_cs, u_rd, rx_valid, cfg_done}), 32'd0);
        base = wr_n;
        @(negedge clk);
        rst = 1'b0;
        wait_for(P_CFG, "midread_cfg_wait", k);
        check("midread_cfg_latency", 32'(k), 32'd19);
        check("midread_cfg_first", 32'(wr_log[base]), 32'({3'd3, 8'h83}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
